// File: rtl/sd_sector_ctrl.sv
// ============================================================================
// Module : sd_sector_ctrl
// Single-sector SD transfer sequencer with a 512x8 buffer, bridging a core
// disk controller to the user_io SD emulation handshake.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sd_sector_ctrl #(
  parameter logic [23:0] TIMEOUT = 24'd12_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [31:0] req_lba,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic [8:0]  buf_addr,
  input  logic [7:0]  buf_din,
  input  logic        buf_we,
  output logic [7:0]  buf_dout,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [7:0]  sd_dout,
  input  logic        sd_dout_strobe,
  output logic [7:0]  sd_din,
  input  logic        sd_din_strobe
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_XFER = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        dir_q, dir_d;
  logic [31:0] lba_q, lba_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [23:0] tmo_q, tmo_d;
  logic [7:0]  din_q;
  logic [7:0]  dout_q;
  logic [7:0]  mem_q [512];

  // Bits [1:0] are the synchroniser, bit [2] holds the previous level for edges.
  logic [2:0]  ack_s_q, dos_s_q, dis_s_q;
  logic        ack_rise, ack_fall, dos_rise, dis_rise;
  logic        sd_we;
  logic [8:0]  rd_ptr;

  assign ack_rise = ack_s_q[1] & ~ack_s_q[2];
  assign ack_fall = ~ack_s_q[1] & ack_s_q[2];
  assign dos_rise = dos_s_q[1] & ~dos_s_q[2];
  assign dis_rise = dis_s_q[1] & ~dis_s_q[2];

  // First strobe is the command fetch, so byte k is presented after strobe k.
  assign rd_ptr = (cnt_q == 10'd0)  ? 9'd0   :
                  (cnt_q > 10'd512) ? 9'h1FF : (cnt_q[8:0] - 9'd1);

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rd_d    = rd_q;
    wr_d    = wr_q;
    dir_d   = dir_q;
    lba_d   = lba_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    sd_we   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_rd || req_wr) begin
          lba_d   = req_lba;
          cnt_d   = 10'd0;
          tmo_d   = 24'd0;
          busy_d  = 1'b1;
          dir_d   = ~req_rd;
          rd_d    = req_rd;
          wr_d    = ~req_rd;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (ack_rise) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = S_XFER;
        end else if (tmo_q == TIMEOUT - 24'd1) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 24'd1;
        end
      end
      S_XFER: begin
        if (ack_fall) begin
          done_d  = 1'b1;
          err_d   = dir_q ? (cnt_q < 10'd512) : (cnt_q != 10'd512);
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (!dir_q && dos_rise && !cnt_q[9]) begin
          sd_we = 1'b1;
          cnt_d = cnt_q + 10'd1;
        end else if (dir_q && dis_rise && (cnt_q != 10'h3FF)) begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      dir_q   <= 1'b0;
      lba_q   <= 32'd0;
      cnt_q   <= 10'd0;
      tmo_q   <= 24'd0;
      din_q   <= 8'd0;
      dout_q  <= 8'd0;
      ack_s_q <= 3'd0;
      dos_s_q <= 3'd0;
      dis_s_q <= 3'd0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      dir_q   <= dir_d;
      lba_q   <= lba_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      ack_s_q <= {ack_s_q[1:0], sd_ack};
      dos_s_q <= {dos_s_q[1:0], sd_dout_strobe};
      dis_s_q <= {dis_s_q[1:0], sd_din_strobe};
      dout_q  <= mem_q[buf_addr];
      if (state_q == S_XFER && dir_q) begin
        din_q <= mem_q[rd_ptr];
      end
    end
  end

  // Core and SD writes are mutually exclusive through busy, so one port suffices.
  always_ff @(posedge clk) begin
    if (sd_we) begin
      mem_q[cnt_q[8:0]] <= sd_dout;
    end else if (buf_we && !busy_q) begin
      mem_q[buf_addr] <= buf_din;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign sd_rd    = rd_q;
  assign sd_wr    = wr_q;
  assign sd_lba   = lba_q;
  assign sd_din   = din_q;
  assign buf_dout = dout_q;

endmodule

`default_nettype wire

// File: doc/sd_sector_ctrl.md
# sd_sector_ctrl

Sequences single-sector (512-byte) SD card transfers between the core and the user_io SD card emulation interface (sd_lba/sd_rd/sd_wr/sd_ack/sd_dout*/sd_din*). Holds a 512×8 sector buffer, raises the read/write request toward the IO controller, resynchronises the SPI-domain strobes into the core clock, counts bytes and reports completion, error or timeout. It sits between a core's disk controller and user_io.

## Interface
- TIMEOUT, default 24'd12_000_000: clk cycles to wait for sd_ack rise before aborting.

- clk  in  1  core clock, ≥ 8× SPI_SCK frequency
- reset_n  in  1  asynchronous, active-low reset
- req_rd  in  1  start sector read (SD→buffer), sampled in IDLE only
- req_wr  in  1  start sector write (buffer→SD), sampled in IDLE only
- req_lba  in  32  sector number, captured with the request
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle, coincident with done on failure
- buf_addr  in  9  core buffer address
- buf_din  in  8  core write data
- buf_we  in  1  core write strobe; ignored while busy
- buf_dout  out  8  buffer read data, registered, 1-cycle latency
- sd_lba  out  32  to user_io
- sd_rd  out  1  to user_io
- sd_wr  out  1  to user_io
- sd_ack  in  1  from user_io, SPI domain
- sd_dout  in  8  from user_io, stable while strobe high and until next byte
- sd_dout_strobe  in  1  from user_io, SPI domain
- sd_din  out  8  to user_io
- sd_din_strobe  in  1  from user_io, SPI domain

## Operation
- Reset: state IDLE; busy, done, err, sd_rd, sd_wr = 0; sd_lba = 0; sd_din = 0; buf_dout = 0; counters 0. Buffer contents undefined.
- sd_ack, sd_dout_strobe, sd_din_strobe each pass through 2-flop synchroniser plus edge-detect register; rising/falling events are used internally.
- States: IDLE → REQ → XFER → IDLE.
- IDLE: on req_rd or req_wr, latch req_lba into sd_lba, clear byte counter (10 bits), set busy, go REQ, asserting sd_rd (read) or sd_wr (write). Both requests high together: read wins.
- REQ: assert sd_rd/sd_wr, count timeout. On sync'd sd_ack rise: deassert sd_rd/sd_wr, go XFER. Timeout reaching TIMEOUT-1: drop request, pulse done+err, go IDLE.
- XFER read: each sd_dout_strobe rise with counter < 512 writes sd_dout into buffer[counter], counter+1; rises beyond 512 ignored.
- XFER write: sd_din = buffer[ptr], ptr = 0 for first strobe, then counter-1, saturating at 511. Each sd_din_strobe rise increments counter (saturate 1023). The first strobe (command fetch) primes; byte k goes out after strobe k.
- XFER exit on sync'd sd_ack fall: success if read counter = 512 or write counter ≥ 512; otherwise err. Pulse done (and err if failed), clear busy, go IDLE.
- Requests arriving while busy are ignored, not queued.
- Core port: buf_dout updated every cycle from buf_addr regardless of state; buf_we honoured only when busy = 0.

## Timing
- busy rises the cycle after the accepted request; sd_rd/sd_wr rise the same cycle.
- SPI-domain event to internal action: 3 clk cycles (2 sync + edge).
- sd_rd/sd_wr fall 3 cycles after sd_ack rise.
- sd_din settles ≤ 4 clk cycles after sd_din_strobe rise, within half an SCK period given clk ≥ 8× SCK.
- done, and err when applicable, pulse 3 cycles after sd_ack fall; busy falls the same cycle done is high.
- Next request is accepted the cycle after done.

## Test plan
- Read: req_rd, lba=0x00001234 → sd_lba=0x1234, sd_rd=1 until ack+3; feed 512 bytes i&0xFF, drop ack → done=1, err=0; buf_addr=0x1FF reads 0xFF.
- Write: preload buffer with ~i, req_wr → sd_wr=1; ack, 513 din strobes, each byte sampled after strobe k equals ~(k-1) → done=1, err=0.
- Short transfer: read with 100 dout strobes, then ack fall → done=1, err=1.
- Timeout: TIMEOUT=100, req_rd with no ack → sd_rd drops, done+err at cycle 100.
- Collisions: req_rd and req_wr together → only sd_rd asserted. req_wr while busy → ignored. buf_we while busy → buffer unchanged.
- Reset mid-XFER: reset_n low → sd_rd, sd_wr, busy, done = 0, state IDLE; new read after release completes normally.
